st_frame_sequencer: RTL and testbench

Sequences one serial frame per start strobe on the bit-level datapath. It consumes the clock enables ce_tact (half-bit, 1 ms) and ce_st (frame start, 100 ms) from the existing enable generator. It handshakes a data word from a requester and shifts the word out on txd as Manchester-coded bits framed by start and stop symbols. It sits between the enable generator and the line driver.

---
 rtl/ser_pkg.sv | 13 +
 rtl/manch_enc.sv | 11 +
 rtl/st_frame_sequencer.sv | 133 +++++++++++++
 tb/tb_st_frame_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the serial frame sequencer and its line coder.
package ser_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_e;

    localparam int START_HALVES = 2;
    localparam int STOP_HALVES  = 2;

    function automatic int frame_tacts(input int nbit);
        return 2 * nbit + START_HALVES + STOP_HALVES;
    endfunction

endpackage

// File: rtl/manch_enc.sv
// Manchester line coder: maps a data bit and its half-bit position to the line level.
module manch_enc (
    input  logic bit_val,
    input  logic second_half,
    output logic level
);

    // First half carries the complement, second half the bit itself.
    assign level = second_half ? bit_val : ~bit_val;

endmodule

// File: rtl/st_frame_sequencer.sv
// Sends one Manchester-coded frame (start, NBIT data bits, stop) per accepted ce_st strobe.
module st_frame_sequencer
    import ser_pkg::*;
#(
    parameter int NBIT      = 8,
    parameter int ST_TACTS  = 100,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce_tact,
    input  logic            ce_st,
    input  logic            tx_req,
    input  logic [NBIT-1:0] tx_data,
    output logic            tx_ack,
    output logic            txd,
    output logic            busy,
    output logic            frame_done,
    output logic            st_miss
);

    localparam int HW = $clog2(2 * NBIT);
    localparam logic [HW-1:0] HALF_LAST  = HW'(2 * NBIT - 1);
    localparam logic [HW-1:0] START_LAST = HW'(START_HALVES - 1);
    localparam logic [HW-1:0] STOP_LAST  = HW'(STOP_HALVES - 1);

    if (NBIT < 1 || NBIT > 32 || frame_tacts(NBIT) > ST_TACTS) begin : g_param_check
        $error("st_frame_sequencer: NBIT out of range or frame longer than the ce_st period");
    end

    ser_state_e      state, state_nx;
    logic [HW-1:0]   half, half_nx;
    logic [NBIT-1:0] shreg, shreg_nx;
    logic            done_nx;
    logic            txd_nx;
    logic            start_ok;
    logic            cur_bit;
    logic            enc_level;

    // A strobe is accepted only from IDLE with a pending request; anything else is a miss.
    assign start_ok = (state == IDLE) && ce_st && tx_req;
    assign tx_ack   = rst_n && start_ok;
    assign st_miss  = rst_n && ce_st && !start_ok;

    always_comb begin
        state_nx = state;
        half_nx  = half;
        shreg_nx = shreg;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = START;
                    half_nx  = '0;
                    shreg_nx = tx_data;
                end
            end
            START: begin
                if (ce_tact) begin
                    if (half == START_LAST) begin
                        state_nx = DATA;
                        half_nx  = '0;
                    end else begin
                        half_nx = half + HW'(1);
                    end
                end
            end
            DATA: begin
                if (ce_tact) begin
                    if (half == HALF_LAST) begin
                        state_nx = STOP;
                        half_nx  = '0;
                    end else begin
                        half_nx = half + HW'(1);
                        // Advance to the next bit at the end of its second half.
                        if (half[0]) begin
                            shreg_nx = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        end
                    end
                end
            end
            STOP: begin
                if (ce_tact) begin
                    if (half == STOP_LAST) begin
                        state_nx = IDLE;
                        half_nx  = '0;
                        done_nx  = 1'b1;
                    end else begin
                        half_nx = half + HW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cur_bit = MSB_FIRST ? shreg_nx[NBIT-1] : shreg_nx[0];

    manch_enc u_enc (
        .bit_val     (cur_bit),
        .second_half (half_nx[0]),
        .level       (enc_level)
    );

    // txd is registered from the next-state view so the line follows the state on the same edge.
    always_comb begin
        txd_nx = 1'b1;
        case (state_nx)
            START:   txd_nx = 1'b0;
            DATA:    txd_nx = enc_level;
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            half       <= '0;
            shreg      <= '0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            half       <= half_nx;
            shreg      <= shreg_nx;
            txd        <= txd_nx;
            busy       <= (state_nx != IDLE);
            frame_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_st_frame_sequencer.sv
// Scoreboard bench: MSB-first and LSB-first instances driven in parallel, checked against a frame-level model.
module tb_st_frame_sequencer;

    localparam int NBIT = 8;
    localparam int FH   = 2 * NBIT + 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ce_tact;
    logic            ce_st;
    logic            tx_req;
    logic [NBIT-1:0] tx_data;

    wire [1:0] tx_ack_w, txd_w, busy_w, done_w, miss_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    st_frame_sequencer #(.NBIT(NBIT), .ST_TACTS(100), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .ce_tact(ce_tact), .ce_st(ce_st),
        .tx_req(tx_req), .tx_data(tx_data),
        .tx_ack(tx_ack_w[0]), .txd(txd_w[0]), .busy(busy_w[0]),
        .frame_done(done_w[0]), .st_miss(miss_w[0])
    );

    st_frame_sequencer #(.NBIT(NBIT), .ST_TACTS(100), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .ce_tact(ce_tact), .ce_st(ce_st),
        .tx_req(tx_req), .tx_data(tx_data),
        .tx_ack(tx_ack_w[1]), .txd(txd_w[1]), .busy(busy_w[1]),
        .frame_done(done_w[1]), .st_miss(miss_w[1])
    );

    // Scoreboard queues, one per instance.
    logic [FH-1:0] exp_fr_q[2][$];
    logic [1:0]    exp_ev_q[2][$];
    bit            abort_pend[2];

    // Reference model state: tact index and end tact of the frame in flight.
    int tidx     = 0;
    bit m_active = 1'b0;
    int m_fend   = 0;
    bit m_ack    = 1'b0;

    logic tact_edge = 1'b0;
    always @(posedge clk) tact_edge <= ce_tact;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Half-bit levels of a whole frame, first half-bit in the top bit.
    function automatic logic [FH-1:0] frame_bits(input logic [NBIT-1:0] w, input bit msb);
        logic [FH-1:0] v;
        bit b;
        v = '0;
        for (int i = 0; i < NBIT; i++) begin
            b = msb ? w[NBIT-1-i] : w[i];
            v[FH-3-2*i] = ~b;
            v[FH-4-2*i] = b;
        end
        v[1] = 1'b1;
        v[0] = 1'b1;
        return v;
    endfunction

    task automatic model_strobe();
        if ((m_active && tidx <= m_fend) || !tx_req) begin
            m_ack = 1'b0;
            for (int g = 0; g < 2; g++) exp_ev_q[g].push_back(2'b01);
        end else begin
            m_ack    = 1'b1;
            m_active = 1'b1;
            m_fend   = tidx + FH;
            for (int g = 0; g < 2; g++) begin
                exp_ev_q[g].push_back(2'b10);
                exp_fr_q[g].push_back(frame_bits(tx_data, g == 0));
            end
        end
    endtask

    // Called at posedge+1; one tact = 4 clocks with ce_tact in the first.
    task automatic do_tact(input bit st);
        ce_tact = 1'b1;
        ce_st   = st;
        if (st) model_strobe();
        @(posedge clk); #1;
        ce_tact = 1'b0;
        ce_st   = 1'b0;
        tidx++;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic slot(input bit req, input logic [NBIT-1:0] d, input int period);
        tx_req  = req;
        tx_data = d;
        do_tact(1'b1);
        if (m_ack) tx_req = 1'b0;
        repeat (period - 1) do_tact(1'b0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        bit            in_frame = 1'b0;
        int            nh       = 0;
        logic [FH-1:0] got      = '0;
        logic [1:0]    ev;
        logic [FH-1:0] ef;

        always @(negedge clk) begin
            if (ce_st) begin
                if (exp_ev_q[g].size() == 0) begin
                    chk($sformatf("i%0d_ev_underflow", g), 1, 0);
                end else begin
                    ev = exp_ev_q[g].pop_front();
                    chk($sformatf("i%0d_ack_miss", g), {tx_ack_w[g], miss_w[g]}, ev);
                end
            end else if (tx_ack_w[g] || miss_w[g]) begin
                chk($sformatf("i%0d_stray_pulse", g), {tx_ack_w[g], miss_w[g]}, 0);
            end

            if (in_frame) begin
                if (busy_w[g]) begin
                    if (tact_edge) begin
                        got = {got[FH-2:0], txd_w[g]};
                        nh++;
                    end
                end else begin
                    in_frame = 1'b0;
                    if (exp_fr_q[g].size() == 0) begin
                        chk($sformatf("i%0d_fr_underflow", g), 1, 0);
                    end else begin
                        ef = exp_fr_q[g].pop_front();
                        if (abort_pend[g]) begin
                            abort_pend[g] = 1'b0;
                            chk($sformatf("i%0d_abort_txd", g), txd_w[g], 1);
                            chk($sformatf("i%0d_abort_done", g), done_w[g], 0);
                        end else begin
                            chk($sformatf("i%0d_frame_done", g), done_w[g], 1);
                            chk($sformatf("i%0d_busy_tacts", g), nh, FH);
                            chk($sformatf("i%0d_frame_bits", g), got, ef);
                        end
                    end
                end
            end else if (busy_w[g] === 1'b1) begin
                in_frame = 1'b1;
                got      = {{(FH-1){1'b0}}, txd_w[g]};
                nh       = 1;
            end else begin
                if (tact_edge) chk($sformatf("i%0d_idle_txd", g), txd_w[g], 1);
                if (done_w[g] === 1'b1) chk($sformatf("i%0d_stray_done", g), done_w[g], 0);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        ce_tact = 1'b0;
        ce_st   = 1'b0;
        tx_req  = 1'b0;
        tx_data = '0;
        abort_pend[0] = 1'b0;
        abort_pend[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("i%0d_rst_txd", g), txd_w[g], 1);
            chk($sformatf("i%0d_rst_busy", g), busy_w[g], 0);
            chk($sformatf("i%0d_rst_done", g), done_w[g], 0);
            chk($sformatf("i%0d_rst_ack", g), tx_ack_w[g], 0);
            chk($sformatf("i%0d_rst_miss", g), miss_w[g], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle strobes without a request.
        repeat (3) slot(1'b0, '0, 100);

        // Directed words at the nominal strobe period.
        slot(1'b1, 8'hA5, 100);
        slot(1'b1, 8'h00, 100);
        slot(1'b1, 8'hFF, 100);
        slot(1'b1, 8'h01, 100);

        // Random words and requests at a tighter strobe period.
        repeat (10) slot($urandom_range(0, 3) != 0, NBIT'($urandom), 25);

        // Strobe every frame length: every second strobe lands on the final STOP tact.
        repeat (4) slot(1'b1, NBIT'($urandom), 20);
        repeat (5) do_tact(1'b0);

        // Reset in the middle of DATA, then a clean frame.
        tx_req  = 1'b1;
        tx_data = NBIT'($urandom);
        do_tact(1'b1);
        tx_req = 1'b0;
        repeat (9) do_tact(1'b0);
        abort_pend[0] = 1'b1;
        abort_pend[1] = 1'b1;
        m_active      = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("i%0d_post_rst_txd", g), txd_w[g], 1);
            chk($sformatf("i%0d_post_rst_busy", g), busy_w[g], 0);
        end
        repeat (80) do_tact(1'b0);
        slot(1'b1, 8'h3C, 100);

        for (int g = 0; g < 2; g++) begin
            chk($sformatf("i%0d_fr_q_left", g), exp_fr_q[g].size(), 0);
            chk($sformatf("i%0d_ev_q_left", g), exp_ev_q[g].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
